pal_macrocell_array: RTL

//  Next-generation programmable AND/OR array with per-output macrocells: optional output register, optional inversion.

---
 rtl/pal_macrocell_array.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pal_macrocell_array.sv
// ---------------------------------------------------------------------------
// pal_macrocell_array
//   Programmable AND/OR array with one macrocell per output. Each macrocell
//   can invert its OR result and can optionally register it. The
//   configuration is shifted in serially, and a commit copies it into the
//   active (shadow) config. A commit is accepted only if exactly CFG_LEN
//   bits were shifted since the last commit or reset.
//
//   Optional feature macro: PAL_READBACK_EN. When it is defined, cfg_dout
//   mirrors chain bit 0. When it is not defined, cfg_dout is tied to 0.
//
// Ports
//   clk        : single clock for config and macrocell registers
//   rst        : synchronous, active-high reset
//   cfg_en     : shift cfg_bit into the chain this cycle
//   cfg_bit    : serial config data
//   cfg_commit : copy the chain into the active config (length checked)
//   cfg_valid  : the active config holds a committed bitstream
//   cfg_err    : the last commit was rejected (bit count != CFG_LEN)
//   cfg_dout   : chain readback (chain bit 0)
//   pal_en     : output enable; when low, pal_out is forced to 0
//   pal_in     : array inputs
//   pal_out    : array outputs
//
// Active config bitmap (A = 2*NI*NT, B = A + NT*NO)
//   t*2*NI + 2*j     : term t uses pal_in[j]
//   t*2*NI + 2*j + 1 : term t uses ~pal_in[j]
//   A + o*NT + t     : term t feeds the OR for output o
//   B + 2*o          : output o is registered
//   B + 2*o + 1      : output o is inverted (inversion happens before the FF)
// ---------------------------------------------------------------------------
module pal_macrocell_array #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_TERMS   = 11,
    parameter int NUM_OUTPUTS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic                   cfg_bit,
    input  logic                   cfg_commit,
    output logic                   cfg_valid,
    output logic                   cfg_err,
    output logic                   cfg_dout,
    input  logic                   pal_en,
    input  logic [NUM_INPUTS-1:0]  pal_in,
    output logic [NUM_OUTPUTS-1:0] pal_out
);
    localparam int NI      = NUM_INPUTS;
    localparam int NT      = NUM_TERMS;
    localparam int NO      = NUM_OUTPUTS;
    localparam int CFG_LEN = 2*NI*NT + NT*NO + 2*NO;
    localparam int OR_BASE = 2*NI*NT;
    localparam int MC_BASE = OR_BASE + NT*NO;
    // The counter must be able to hold CFG_LEN+1, which marks an overlength load.
    localparam int CNT_W   = $clog2(CFG_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CFG_LEN + 1);

    logic [CFG_LEN-1:0] sr_reg;
    logic [CFG_LEN-1:0] active_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               cfg_valid_reg;
    logic               cfg_err_reg;
    logic [NO-1:0]      ff_reg;

    logic [NT-1:0]      term_val;
    logic [NO-1:0]      mc_d;       // OR result after optional inversion
    logic               commit_ok;
    logic               run;

    assign commit_ok = cfg_commit && (count_reg == CNT_FULL);
    assign run       = pal_en & cfg_valid_reg;

    // ------------------------------------------------------------------
    // AND plane. A term with an empty literal mask evaluates 0. Without
    // that rule, an unprogrammed term would read as constant 1.
    // ------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < NT; gi++) begin : g_term
            logic [2*NI-1:0] lits;
            logic [2*NI-1:0] mask;
            for (gj = 0; gj < NI; gj++) begin : g_lit
                assign lits[2*gj]   = pal_in[gj];
                assign lits[2*gj+1] = ~pal_in[gj];
            end
            assign mask         = active_reg[gi*2*NI +: 2*NI];
            assign term_val[gi] = (|mask) & (&(lits | ~mask));
        end

        // --------------------------------------------------------------
        // OR plane and macrocells.
        // --------------------------------------------------------------
        for (gi = 0; gi < NO; gi++) begin : g_out
            logic or_res;
            assign or_res      = |(term_val & active_reg[OR_BASE + gi*NT +: NT]);
            assign mc_d[gi]    = or_res ^ active_reg[MC_BASE + 2*gi + 1];
            assign pal_out[gi] = run ? (active_reg[MC_BASE + 2*gi] ? ff_reg[gi] : mc_d[gi])
                                     : 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Config chain, length counter, active config and macrocell FFs.
    // A commit takes priority over a shift in the same cycle. The commit
    // sees the pre-shift count, and the shift bit is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg        <= '0;
            active_reg    <= '0;
            count_reg     <= '0;
            cfg_valid_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
            ff_reg        <= '0;
        end else begin
            if (cfg_commit) begin
                count_reg <= '0;
                if (commit_ok) begin
                    active_reg    <= sr_reg;
                    cfg_valid_reg <= 1'b1;
                    cfg_err_reg   <= 1'b0;
                end else begin
                    cfg_err_reg   <= 1'b1;
                end
            end else if (cfg_en) begin
                sr_reg <= {cfg_bit, sr_reg[CFG_LEN-1:1]};
                if (count_reg != CNT_OVER)
                    count_reg <= count_reg + 1'b1;
            end

            // A newly accepted config starts from cleared macrocell state.
            if (commit_ok)
                ff_reg <= '0;
            else if (run)
                ff_reg <= mc_d;
        end
    end

    assign cfg_valid = cfg_valid_reg;
    assign cfg_err   = cfg_err_reg;

`ifdef PAL_READBACK_EN
    assign cfg_dout = sr_reg[0];
`else
    assign cfg_dout = 1'b0;
`endif

endmodule
